// File: rtl/sum_window_accum.sv
// sum_window_accum
// Accumulates fixed windows of 2**LOG2_WIN unsigned samples under a
// valid/ready handshake and presents each window's full-width sum and
// truncated (floor) average on a held output with valid/ready backpressure.
//
// state | meaning
// ------+--------------------------------------------------------------
// ACCUM | accepting samples into the current window, in_ready = 1
// HOLD  | completed result held on out_*; input only accepted on a take
//
// Legal LOG2_WIN range is 1..8. The sum never overflows because
// WIN*(2**DATAWIDTH-1) < 2**(DATAWIDTH+LOG2_WIN).
module sum_window_accum #(
  parameter int DATAWIDTH = 8,
  parameter int LOG2_WIN  = 2
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic [DATAWIDTH-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [DATAWIDTH+LOG2_WIN-1:0] out_sum,
  output logic [DATAWIDTH-1:0]          out_avg,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LOG2_WIN-1:0]           win_cnt
);

  localparam int ACCWIDTH = DATAWIDTH + LOG2_WIN;
  localparam int WIN      = 2 ** LOG2_WIN;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ACCWIDTH-1:0]   acc_q, acc_d;
  logic [LOG2_WIN-1:0]   cnt_q, cnt_d;
  logic [ACCWIDTH-1:0]   sum_q, sum_d;
  logic [DATAWIDTH-1:0]  avg_q, avg_d;
  logic                  valid_q, valid_d;

  logic                  accept;
  logic                  take;
  logic                  last;
  logic [ACCWIDTH-1:0]   sum_in;

  // Input readiness depends only on state and downstream readiness, never on
  // in_valid, so upstream can't form a combinational loop through us.
  always_comb begin
    in_ready = 1'b1;
    if (state_q == HOLD) begin
      in_ready = out_ready;
    end
  end

  assign accept = in_valid & in_ready;
  assign take   = valid_q & out_ready;
  assign last   = (cnt_q == LOG2_WIN'(WIN - 1));
  assign sum_in = acc_q + ACCWIDTH'(in_data);

  // Next-state and datapath: window completion latches the result and
  // clears the accumulator; a take in HOLD may start the next window at once.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    avg_d   = avg_q;
    valid_d = valid_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (last) begin
            sum_d   = sum_in;
            avg_d   = sum_in[ACCWIDTH-1:LOG2_WIN];
            valid_d = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            acc_d = sum_in;
            cnt_d = cnt_q + LOG2_WIN'(1);
          end
        end
      end
      HOLD: begin
        if (take) begin
          valid_d = 1'b0;
          state_d = ACCUM;
          // A sample accepted alongside the take opens the next window.
          if (accept) begin
            acc_d = ACCWIDTH'(in_data);
            cnt_d = LOG2_WIN'(1);
          end
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial window.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      avg_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      avg_q   <= avg_d;
      valid_q <= valid_d;
    end
  end

  assign out_sum   = sum_q;
  assign out_avg   = avg_q;
  assign out_valid = valid_q;
  assign win_cnt   = cnt_q;

endmodule

// File: tb/tb_sum_window_accum.sv
// Testbench for sum_window_accum: directed scenarios followed by random
// traffic, checked against a sample-list reference model and a result
// scoreboard.
module tb_sum_window_accum;

  localparam int DW  = 8;
  localparam int L2W = 2;
  localparam int WIN = 2 ** L2W;

  logic            Clk = 1'b0;
  logic            Rst = 1'b1;
  logic [DW-1:0]   in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW+L2W-1:0] out_sum;
  logic [DW-1:0]   out_avg;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [L2W-1:0]  win_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  sum_window_accum #(.DATAWIDTH(DW), .LOG2_WIN(L2W)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_sum  (out_sum),
    .out_avg  (out_avg),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .win_cnt  (win_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int  part[$];        // samples accepted into the open window
  int  sb[$];          // expected window sums, oldest first
  bit  pending = 0;    // a completed result is waiting to be taken
  bit  armed   = 0;    // DUT has seen a reset edge
  int  exp_sum = 0;
  int  m_sum;
  bit  m_take, m_acc;

  // Compare observable state with the model, then advance the model by
  // what the coming edge will do.
  always @(negedge Clk) begin
    if (armed) begin
      chk("out_valid", int'(out_valid), int'(pending));
      chk("in_ready", int'(in_ready), int'(!pending || out_ready));
      chk("win_cnt", int'(win_cnt), part.size());
      chk("out_sum_held", int'(out_sum), exp_sum);
      chk("out_avg_held", int'(out_avg), exp_sum / WIN);
    end
    if (Rst) begin
      pending = 0;
      part.delete();
      sb.delete();
      exp_sum = 0;
      armed   = 1;
    end else begin
      m_take = pending && out_ready;
      m_acc  = in_valid && (!pending || out_ready);
      if (m_take) pending = 0;
      if (m_acc) begin
        part.push_back(int'(in_data));
        if (part.size() == WIN) begin
          m_sum = 0;
          foreach (part[i]) m_sum += part[i];
          exp_sum = m_sum;
          sb.push_back(m_sum);
          pending = 1;
          part.delete();
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge Clk) begin
    if (armed && !Rst && out_valid) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_result", 1, 0);
      end else begin
        chk("sb_sum", int'(out_sum), sb[0]);
        chk("sb_avg", int'(out_avg), sb[0] / WIN);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input int d);
    bit done;
    int n;
    done = 0;
    n = 0;
    in_valid = 1'b1;
    in_data  = DW'(d);
    while (!done) begin
      @(negedge Clk);
      done = in_ready;
      tick();
      n++;
      if (!done && n > 50) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    Rst = 1'b1;
    repeat (2) tick();
    Rst = 1'b0;
    tick();

    // basic window, then a max-value window
    out_ready = 1'b1;
    send(10); send(20); send(30); send(40);
    gap(2);
    send(255); send(255); send(255); send(255);
    gap(2);

    // backpressure, then a sample accepted together with the take
    out_ready = 1'b0;
    send(1); send(2); send(3); send(4);
    in_valid = 1'b1;
    in_data  = 8'd99;
    repeat (3) tick();
    out_ready = 1'b1;
    send(7); send(8); send(9); send(10);
    gap(2);

    // reset mid-window discards the partial sum
    send(50); send(60);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    send(1); send(1); send(1); send(1);
    gap(2);

    // gaps between samples, truncating average
    send(1); gap(2); send(1); gap(2); send(1); gap(2); send(2); gap(2);

    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = ($urandom_range(0, 3) == 0) ? 8'd255 : DW'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 9) < 6);
      Rst       = ($urandom_range(0, 149) == 0);
      tick();
    end
    Rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
